rv23_regfile_sb: RTL
====================

# rv23_regfile_sb

Parametrised multi-port integer register file for the 23RV core with write-to-read bypass and a per-register scoreboard of pending writes. It replaces the fixed 2-read/1-write register file in the decode/writeback path. Decode issues destination registers and stalls on busy sources. Writeback ports commit results and clear pending state.

## Interface
Parameters:
- ADDRESS_BITWIDTH, 5, register address width; NUM_REGS = 1 << ADDRESS_BITWIDTH
- DATA_WIDTH, 32, register width
- NUM_READ, 2, number of read ports (1..4)
- NUM_WRITE, 2, number of write ports (1..2)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored array only

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset; sampled on clk rising edge
- rs  in  NUM_READ*ADDRESS_BITWIDTH  read addresses, port p at [p*AW +: AW]
- rdata  out  NUM_READ*DATA_WIDTH  read data, port p at [p*DW +: DW]
- rbusy  out  NUM_READ  scoreboard bit of rs[p] (0 for x0)
- wa  in  NUM_WRITE*ADDRESS_BITWIDTH  write addresses
- wd  in  NUM_WRITE*DATA_WIDTH  write data
- we  in  NUM_WRITE  write enables
- issue_valid  in  1  decode requests to mark issue_rd pending
- issue_rd  in  ADDRESS_BITWIDTH  destination register being issued
- issue_ready  out  1  issue accepted this cycle if issue_valid also high
- flush  in  1  clear all pending bits (pipeline squash)
- busy_count  out  ADDRESS_BITWIDTH+1  number of registers currently pending

## Operation
- State consists of the array regs[1..NUM_REGS-1] and the busy[NUM_REGS-1:1] bits. x0 has no storage and no busy bit.
- Reads are combinational. rdata[p] is:
  - 0 if rs[p]==0.
  - Otherwise, if BYPASS and some we[w] with wa[w]==rs[p] and reset high, wd of the highest such w.
  - Otherwise regs[rs[p]].
- rbusy[p] = busy[rs[p]] as currently registered. It is not affected by same-cycle writes or issues.
- Writes: on edge, for each register r≠0, if any we[w] with wa[w]==r, regs[r] takes wd of the highest-index w (higher port wins on collision). Writes to x0 are dropped.
- Scoreboard next-state for r≠0, evaluated in precedence order:
  1. reset low → 0
  2. flush → 0
  3. issue accepted with issue_rd==r → 1
  4. any we[w] with wa[w]==r → 0
  5. else hold
- issue_ready = reset & ~flush & (issue_rd==0 | ~busy[issue_rd]). An accepted issue to x0 has no effect.
- Issue and write to the same register in the same cycle: busy ends set (new producer), and regs takes the write data.
- Flush does not block writes. Writes in a flush cycle commit.
- busy_count is registered and equals the popcount of busy after each edge. Its range is 0..NUM_REGS-1, with no wrap.
- Reset (low at edge): all regs cleared to 0, all busy cleared, busy_count 0, regardless of we/issue/flush. Mid-operation reset discards in-flight state. While reset is low, bypass is disabled and issue_ready=0.

## Timing
- Read latency 0 cycles, combinational from rs/wa/wd/we.
- Write visible through the array on the first read after the edge. With BYPASS=1 it is also visible in the write cycle.
- Issue → rbusy high 1 cycle later. Write → rbusy low 1 cycle later.
- busy_count updates 1 cycle after the causing event.
- Reset values: rdata 0 for all addresses, rbusy 0, busy_count 0. issue_ready is 0 while reset is low and 1 in the first cycle after release (issue_rd not busy).

## Test plan
- Reset: write x5=0xDEAD, pulse reset low 1 cycle → every rs 0..31 reads 0, busy_count=0, rbusy all 0.
- Dual-write collision: we=2'b11, wa0=wa1=7, wd0=0x11, wd1=0x22 → next cycle x7=0x22. Also wa0=0, wd0=0x33 → x0 still reads 0.
- Bypass: BYPASS=1, rs0=9, write x9=0xABCD in the same cycle → rdata0=0xABCD that cycle. BYPASS=0 → old value (0) that cycle, 0xABCD next cycle.
- Scoreboard: issue x3 → issue x3 again next cycle sees issue_ready=0 and rbusy=1. Write x3 → rbusy=0, busy_count back to 0. Same-cycle issue+write x3 → busy stays 1.
- Flush: issue x1..x4 over 4 cycles (busy_count=4), then flush with a concurrent write x10=5 → busy_count=0, x10=5, issue in the flush cycle is ignored.
- x0 and full scoreboard: issue x0 → busy_count unchanged. Issue all x1..x31 → busy_count=31, no wrap. Reset mid-sequence → busy_count=0 after that edge.

Source files
------------

// File: rtl/rv23_regfile_sb.sv
// rv23_regfile_sb: multi-port integer register file with write-to-read bypass
// and a per-register scoreboard of pending writes. x0 has no storage and no busy bit.
module rv23_regfile_sb #(
  parameter int unsigned ADDRESS_BITWIDTH = 5,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned NUM_READ         = 2,
  parameter int unsigned NUM_WRITE        = 2,
  parameter bit          BYPASS           = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_READ*ADDRESS_BITWIDTH-1:0]  rs,
  output logic [NUM_READ*DATA_WIDTH-1:0]        rdata,
  output logic [NUM_READ-1:0]                   rbusy,
  input  logic [NUM_WRITE*ADDRESS_BITWIDTH-1:0] wa,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]       wd,
  input  logic [NUM_WRITE-1:0]                  we,
  input  logic                                  issue_valid,
  input  logic [ADDRESS_BITWIDTH-1:0]           issue_rd,
  output logic                                  issue_ready,
  input  logic                                  flush,
  output logic [ADDRESS_BITWIDTH:0]             busy_count
);

  localparam int unsigned AW       = ADDRESS_BITWIDTH;
  localparam int unsigned DW       = DATA_WIDTH;
  localparam int unsigned NUM_REGS = 1 << AW;

  logic [DW-1:0]       regs_q  [1:NUM_REGS-1];
  logic [NUM_REGS-1:1] busy_q;
  logic [NUM_REGS-1:1] busy_d;
  logic [AW:0]         busy_count_q;
  logic [AW:0]         busy_count_d;

  logic [NUM_REGS-1:1] wr_hit;
  logic [DW-1:0]       wr_data [1:NUM_REGS-1];
  logic [DW-1:0]       reg_view [NUM_REGS];
  logic [NUM_REGS-1:0] busy_view;
  logic                issue_acc;

  // Per-register write decode; a higher-index port overrides a lower one.
  always_comb begin
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      wr_hit[r]  = 1'b0;
      wr_data[r] = '0;
      for (int unsigned w = 0; w < NUM_WRITE; w++) begin
        if (we[w] && (wa[w*AW +: AW] == AW'(r))) begin
          wr_hit[r]  = 1'b1;
          wr_data[r] = wd[w*DW +: DW];
        end
      end
    end
  end

  // Zero-extended views so x0 can be indexed like any other register.
  always_comb begin
    reg_view[0] = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      reg_view[r] = regs_q[r];
    end
    busy_view = {busy_q, 1'b0};
  end

  // Issue handshake: refuse while in reset, during flush, or on a busy destination.
  always_comb begin
    issue_ready = reset & ~flush & ((issue_rd == '0) | ~busy_view[issue_rd]);
    issue_acc   = issue_valid & issue_ready;
  end

  // Scoreboard next state and its popcount; issue beats a same-cycle write.
  always_comb begin
    busy_d       = busy_q;
    busy_count_d = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (issue_acc && (issue_rd == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wr_hit[r]) begin
        busy_d[r] = 1'b0;
      end
      busy_count_d = busy_count_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  // Combinational read ports with optional same-cycle forwarding of write data.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int unsigned p = 0; p < NUM_READ; p++) begin
      rdata[p*DW +: DW] = reg_view[rs[p*AW +: AW]];
      rbusy[p]          = busy_view[rs[p*AW +: AW]];
      if (BYPASS && reset && (rs[p*AW +: AW] != '0)) begin
        for (int unsigned w = 0; w < NUM_WRITE; w++) begin
          if (we[w] && (wa[w*AW +: AW] == rs[p*AW +: AW])) begin
            rdata[p*DW +: DW] = wd[w*DW +: DW];
          end
        end
      end
    end
  end

  // State update with synchronous active-low reset; flush never blocks writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (wr_hit[r]) begin
          regs_q[r] <= wr_data[r];
        end
      end
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

endmodule
